// File: rtl/layer_fifo_adapt.sv
// layer_fifo_adapt
//   Inter-layer stream FIFO between conv stages with lane-count adaptation.
//   The producer writes IN_LANES lanes per beat and the consumer reads
//   OUT_LANES lanes per beat. Three modes are supported:
//     - equal    (IN == OUT): plain FIFO.
//     - downsize (IN  > OUT): each stored word is read back over k beats.
//     - upsize   (IN  < OUT): k write beats are packed into one stored word.
//   Every stored word is MAXL = max(IN_LANES, OUT_LANES) lanes wide. Read
//   data is show-ahead: a combinational mux of the head word, forced to zero
//   while empty.
//   Optional feature: define LAYER_FIFO_PEAK_EN to track a high-water mark of
//   count on peak_count. Without it peak_count is tied to zero.
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   wr_data/wr_en  write beat (lane 0 in LSBs) and strobe
//   full           no free stored word
//   almost_full    count >= ALMOST_FULL_THRES (upstream backpressure)
//   rd_data/rd_en  show-ahead head beat and pop strobe
//   empty          no readable beat
//   count          stored words; an incomplete pack is not counted
//   overflow       sticky: a write was dropped because the FIFO was full
//   underflow      sticky: a read was issued while empty
//   peak_count     high-water mark of count (LAYER_FIFO_PEAK_EN only)
module layer_fifo_adapt #(
    parameter int LANE_WIDTH        = 8,
    parameter int IN_LANES          = 2,
    parameter int OUT_LANES         = 2,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_THRES = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [LANE_WIDTH*IN_LANES-1:0]   wr_data,
    input  logic                             wr_en,
    output logic                             full,
    output logic                             almost_full,
    output logic [LANE_WIDTH*OUT_LANES-1:0]  rd_data,
    input  logic                             rd_en,
    output logic                             empty,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             overflow,
    output logic                             underflow,
    output logic [$clog2(DEPTH):0]           peak_count
);

    localparam int MAXL = (IN_LANES > OUT_LANES) ? IN_LANES : OUT_LANES;
    localparam int MINL = (IN_LANES > OUT_LANES) ? OUT_LANES : IN_LANES;
    localparam int K    = MAXL / MINL;
    localparam int KW   = (K > 1) ? $clog2(K) : 1;
    localparam int IW   = LANE_WIDTH * IN_LANES;
    localparam int OW   = LANE_WIDTH * OUT_LANES;
    localparam int MW   = LANE_WIDTH * MAXL;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;

    logic [MW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic          commit;       // a full word enters storage this edge
    logic          retire;       // the head word leaves storage this edge
    logic          drop;         // write beat lost because storage is full
    logic          rd_ok;        // a read beat is consumed this edge
    logic [MW-1:0] commit_word;
    logic [MW-1:0] head_word;
    logic [OW-1:0] head_beat;

    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(ALMOST_FULL_THRES));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign rd_ok       = rd_en && !empty;
    assign head_word   = mem[rd_ptr];
    assign rd_data     = empty ? '0 : head_beat;

    // Write side: either pass beats straight through or pack them.
    if (OUT_LANES > IN_LANES) begin : g_pack
        logic [KW-1:0]    pack_idx;
        logic [MW-IW-1:0] pack_reg;
        logic             last_beat;

        assign last_beat   = (pack_idx == KW'(K - 1));
        // Earlier beats only touch the pack register, so they are taken
        // even while full; only the completing beat needs a free slot.
        assign commit      = wr_en && last_beat && !full;
        assign drop        = wr_en && last_beat && full;
        assign commit_word = {wr_data, pack_reg};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pack_idx <= '0;
            end else if (wr_en && !drop) begin
                pack_idx <= last_beat ? '0 : pack_idx + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en && !last_beat) begin
                pack_reg[int'(pack_idx)*IW +: IW] <= wr_data;
            end
        end
    end else begin : g_direct_wr
        assign commit      = wr_en && !full;
        assign drop        = wr_en && full;
        assign commit_word = wr_data;
    end

    // Read side: either hand out whole words or split them into beats.
    if (IN_LANES > OUT_LANES) begin : g_split
        logic [KW-1:0] split_idx;

        assign retire    = rd_ok && (split_idx == KW'(K - 1));
        assign head_beat = head_word[int'(split_idx)*OW +: OW];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                split_idx <= '0;
            end else if (rd_ok) begin
                split_idx <= retire ? '0 : split_idx + 1'b1;
            end
        end
    end else begin : g_direct_rd
        assign retire    = rd_ok;
        assign head_beat = head_word;
    end

    // Control state: pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (commit) wr_ptr <= wr_ptr + 1'b1;
            if (retire) rd_ptr <= rd_ptr + 1'b1;
            case ({commit, retire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop)           overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    // Storage array is data only and is deliberately left uncleared.
    always_ff @(posedge clk) begin
        if (commit) mem[wr_ptr] <= commit_word;
    end

`ifdef LAYER_FIFO_PEAK_EN
    logic [CW-1:0] peak_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (count_q > peak_q) begin
            peak_q <= count_q;
        end
    end

    assign peak_count = peak_q;
`else
    assign peak_count = '0;
`endif

endmodule

// File: tb/tb_layer_fifo_adapt.sv
// Bench for layer_fifo_adapt. Three instances share clk/rst_n:
//   inst 0: equal    IN=2 OUT=2
//   inst 1: downsize IN=2 OUT=1
//   inst 2: upsize   IN=1 OUT=2
// Directed table + hand sequences, then randomized traffic against a
// lane-queue reference model.
module tb_layer_fifo_adapt;

    localparam int NI    = 3;
    localparam int DEPTH = 16;
    localparam int THRES = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        w_en   [NI];
    logic [15:0] w_data [NI];
    logic        r_en   [NI];
    logic [4:0]  a_cnt  [NI];
    logic [4:0]  a_peak [NI];
    logic        a_full [NI];
    logic        a_af   [NI];
    logic        a_empty[NI];
    logic        a_ovf  [NI];
    logic        a_unf  [NI];
    logic [15:0] a_rd   [NI];
    logic [7:0]  rd_down;

    assign a_rd[1] = {8'h00, rd_down};

    layer_fifo_adapt #(.LANE_WIDTH(8), .IN_LANES(2), .OUT_LANES(2), .DEPTH(DEPTH),
                       .ALMOST_FULL_THRES(THRES)) u_eq (
        .clk(clk), .rst_n(rst_n), .wr_data(w_data[0]), .wr_en(w_en[0]),
        .full(a_full[0]), .almost_full(a_af[0]), .rd_data(a_rd[0]), .rd_en(r_en[0]),
        .empty(a_empty[0]), .count(a_cnt[0]), .overflow(a_ovf[0]), .underflow(a_unf[0]),
        .peak_count(a_peak[0]));

    layer_fifo_adapt #(.LANE_WIDTH(8), .IN_LANES(2), .OUT_LANES(1), .DEPTH(DEPTH),
                       .ALMOST_FULL_THRES(THRES)) u_down (
        .clk(clk), .rst_n(rst_n), .wr_data(w_data[1]), .wr_en(w_en[1]),
        .full(a_full[1]), .almost_full(a_af[1]), .rd_data(rd_down), .rd_en(r_en[1]),
        .empty(a_empty[1]), .count(a_cnt[1]), .overflow(a_ovf[1]), .underflow(a_unf[1]),
        .peak_count(a_peak[1]));

    layer_fifo_adapt #(.LANE_WIDTH(8), .IN_LANES(1), .OUT_LANES(2), .DEPTH(DEPTH),
                       .ALMOST_FULL_THRES(THRES)) u_up (
        .clk(clk), .rst_n(rst_n), .wr_data(w_data[2][7:0]), .wr_en(w_en[2]),
        .full(a_full[2]), .almost_full(a_af[2]), .rd_data(a_rd[2]), .rd_en(r_en[2]),
        .empty(a_empty[2]), .count(a_cnt[2]), .overflow(a_ovf[2]), .underflow(a_unf[2]),
        .peak_count(a_peak[2]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", nm, i, act, exp, $time);
        end
    endtask

    function automatic int inl(int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic int outl(int i);
        return (i == 1) ? 1 : 2;
    endfunction

    // ---------------- reference model: lanes in flight ----------------
    logic [7:0] mq [NI][$];   // committed lanes, head first
    logic [7:0] pq [NI][$];   // lanes of an incomplete upsize pack
    bit         m_ovf [NI];
    bit         m_unf [NI];
    int         m_peak[NI];

    // Stored words = committed lanes rounded up to whole 2-lane words.
    function automatic int m_count(int i);
        return (mq[i].size() + 1) / 2;
    endfunction

    function automatic logic [15:0] m_rd(int i);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < outl(i); k++) r[8*k +: 8] = mq[i][k];
        return r;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            pq[i].delete();
            m_ovf[i]  = 0;
            m_unf[i]  = 0;
            m_peak[i] = 0;
        end
    endfunction

    function automatic void m_step(int i, logic wen, logic [15:0] wd, logic ren);
        int c;
        bit e, f;
        c = m_count(i);
        e = (c == 0);
        f = (c == DEPTH);
        if (c > m_peak[i]) m_peak[i] = c;
        if (ren) begin
            if (e) m_unf[i] = 1;
            else for (int k = 0; k < outl(i); k++) void'(mq[i].pop_front());
        end
        if (wen) begin
            if (inl(i) >= outl(i)) begin
                if (f) m_ovf[i] = 1;
                else for (int k = 0; k < inl(i); k++) mq[i].push_back(wd[8*k +: 8]);
            end else if (pq[i].size() + inl(i) < 2) begin
                for (int k = 0; k < inl(i); k++) pq[i].push_back(wd[8*k +: 8]);
            end else if (f) begin
                m_ovf[i] = 1;
            end else begin
                foreach (pq[i][k]) mq[i].push_back(pq[i][k]);
                pq[i].delete();
                for (int k = 0; k < inl(i); k++) mq[i].push_back(wd[8*k +: 8]);
            end
        end
    endfunction

    function automatic int exp_peak(int model_peak);
`ifdef LAYER_FIFO_PEAK_EN
        return model_peak;
`else
        return 0 * model_peak;
`endif
    endfunction

    // ---------------- drive helpers ----------------
    task automatic clear_inputs();
        for (int i = 0; i < NI; i++) begin
            w_en[i] = 0; w_data[i] = '0; r_en[i] = 0;
        end
    endtask

    // One beat on one instance; outputs are stable for checking on return.
    task automatic drive(input int i, input logic wen, input logic [15:0] wd, input logic ren);
        @(negedge clk);
        clear_inputs();
        w_en[i] = wen; w_data[i] = wd; r_en[i] = ren;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        m_clear();
    endtask

    typedef struct {
        int          inst;
        logic        wen;
        logic [15:0] wd;
        logic        ren;
        logic        e_empty;
        int          e_cnt;
        logic [15:0] e_rd;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        clear_inputs();
        m_clear();

        // Expected state after each applied beat.
        tbl[0] = '{1, 1'b1, 16'hBBAA, 1'b0, 1'b0, 1, 16'h00AA, 1'b0, 1'b0};
        tbl[1] = '{1, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h00BB, 1'b0, 1'b0};
        tbl[2] = '{1, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{2, 1'b1, 16'h0011, 1'b0, 1'b1, 0, 16'h0000, 1'b0, 1'b0};
        tbl[4] = '{2, 1'b1, 16'h0022, 1'b0, 1'b0, 1, 16'h2211, 1'b0, 1'b0};
        tbl[5] = '{2, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 16'h0000, 1'b0, 1'b0};
        tbl[6] = '{0, 1'b1, 16'h0033, 1'b1, 1'b0, 1, 16'h0033, 1'b0, 1'b1};
        tbl[7] = '{0, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 16'h0000, 1'b0, 1'b1};
        tbl[8] = '{1, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 16'h0000, 1'b0, 1'b1};

        // Reset state, all instances.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_empty", i, a_empty[i], 1);
            chk("rst_full", i, a_full[i], 0);
            chk("rst_af", i, a_af[i], 0);
            chk("rst_count", i, a_cnt[i], 0);
            chk("rst_rd", i, a_rd[i], 0);
            chk("rst_ovf", i, a_ovf[i], 0);
            chk("rst_unf", i, a_unf[i], 0);
            chk("rst_peak", i, a_peak[i], 0);
        end
        @(negedge clk);
        rst_n = 1;

        // Directed table: downsize split, upsize pack, read-on-empty.
        foreach (tbl[r]) begin
            drive(tbl[r].inst, tbl[r].wen, tbl[r].wd, tbl[r].ren);
            chk("tbl_empty", tbl[r].inst, a_empty[tbl[r].inst], tbl[r].e_empty);
            chk("tbl_count", tbl[r].inst, a_cnt[tbl[r].inst], tbl[r].e_cnt);
            if (!tbl[r].e_empty) chk("tbl_rd", tbl[r].inst, a_rd[tbl[r].inst], tbl[r].e_rd);
            chk("tbl_ovf", tbl[r].inst, a_ovf[tbl[r].inst], tbl[r].e_ovf);
            chk("tbl_unf", tbl[r].inst, a_unf[tbl[r].inst], tbl[r].e_unf);
        end

        // Equal mode fill to full, drop on full, simultaneous rd+wr on full, drain.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, {8'(2*i+1), 8'(2*i)}, 0);
            chk("fill_count", 0, a_cnt[0], i + 1);
            chk("fill_af", 0, a_af[0], (i + 1 >= THRES));
            chk("fill_full", 0, a_full[0], (i + 1 == DEPTH));
        end
        drive(0, 1, 16'hEEEE, 0);
        chk("drop_ovf", 0, a_ovf[0], 1);
        chk("drop_count", 0, a_cnt[0], DEPTH);
        chk("drop_head", 0, a_rd[0], 16'h0100);
        drive(0, 1, 16'hDDDD, 1);
        chk("rdwr_full_count", 0, a_cnt[0], DEPTH - 1);
        chk("rdwr_full_full", 0, a_full[0], 0);
        for (int i = 1; i < DEPTH; i++) begin
            chk("drain_rd", 0, a_rd[0], {8'(2*i+1), 8'(2*i)});
            drive(0, 0, 16'h0000, 1);
        end
        chk("drain_empty", 0, a_empty[0], 1);
        chk("drain_count", 0, a_cnt[0], 0);
        chk("drain_unf", 0, a_unf[0], 0);

        // Async reset mid-stream on the upsize instance (5 words + 1 packed beat).
        do_reset();
        for (int i = 0; i < 11; i++) drive(2, 1, 16'(i + 1), 0);
        drive(2, 0, 16'h0000, 0);
        chk("mid_count", 2, a_cnt[2], 5);
        chk("mid_peak", 2, a_peak[2], exp_peak(5));
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async_count", 2, a_cnt[2], 0);
        chk("async_empty", 2, a_empty[2], 1);
        chk("async_rd", 2, a_rd[2], 0);
        chk("async_peak", 2, a_peak[2], 0);
        @(negedge clk);
        rst_n = 1;
        drive(2, 1, 16'h00AA, 0);
        chk("post_rst_pack_empty", 2, a_empty[2], 1);
        drive(2, 1, 16'h00BB, 0);
        chk("post_rst_pack_rd", 2, a_rd[2], 16'hBBAA);

        // Randomized traffic vs. model, alternating fill-heavy and drain-heavy phases.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int pw, pr;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("rnd_count", i, a_cnt[i], m_count(i));
                chk("rnd_empty", i, a_empty[i], m_count(i) == 0);
                chk("rnd_full", i, a_full[i], m_count(i) == DEPTH);
                chk("rnd_af", i, a_af[i], m_count(i) >= THRES);
                chk("rnd_ovf", i, a_ovf[i], m_ovf[i]);
                chk("rnd_unf", i, a_unf[i], m_unf[i]);
                chk("rnd_peak", i, a_peak[i], exp_peak(m_peak[i]));
                if (m_count(i) != 0) chk("rnd_rd", i, a_rd[i], m_rd(i));
            end
            pw = ((cyc / 150) % 2 == 0) ? 80 : 30;
            pr = 110 - pw;
            for (int i = 0; i < NI; i++) begin
                w_en[i]   = ($urandom_range(99) < pw);
                w_data[i] = 16'($urandom);
                r_en[i]   = ($urandom_range(99) < pr);
            end
            @(posedge clk);
            for (int i = 0; i < NI; i++) m_step(i, w_en[i], w_data[i], r_en[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
